// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and default sizes for cpu_memory
package cpu_mem_pkg;

  localparam int CPU_MEM_ADDR_W = 8;
  localparam int CPU_MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } cpu_mem_state_t;

endpackage

// File: rtl/cpu_mem_array.sv
// rtl/cpu_mem_array.sv - single-port RAM, one write and one registered read
// Optional macro CPU_MEM_WR_BYPASS_EN: a read with a write on the same edge
// returns the new write data (write-first); otherwise it returns the old word.
module cpu_mem_array
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = CPU_MEM_ADDR_W,
  parameter int DATA_W = CPU_MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; deliberately no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read port, forced to zero while reads are disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !rd_en) begin
      rdata <= '0;
`ifdef CPU_MEM_WR_BYPASS_EN
    end else if (we) begin
      rdata <= wdata;
`endif
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/cpu_memory.sv
// rtl/cpu_memory.sv - boot-loaded CPU memory with hold-in-reset sequencing
// The read/write bypass behaviour is selected by macro CPU_MEM_WR_BYPASS_EN
// inside cpu_mem_array.
module cpu_memory
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = CPU_MEM_ADDR_W,
  parameter int DATA_W = CPU_MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              wea,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   ld_count
);

  // Count ceiling equals the memory depth.
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  cpu_mem_state_t    state;
  logic              ld_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;

  assign ld_fire = ld_valid && ld_ready && (state == BOOT);
  assign rd_en   = (state == RUN);

  // Port mux: loader owns the RAM in BOOT, CPU in RUN, nobody in RELEASE or reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = data_in;
    if (state == BOOT) begin
      mem_we    = ld_fire;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else if (state == RUN) begin
      mem_we    = wea;
    end
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  // Boot sequencer: load words, one RELEASE cycle, then run until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      ld_ready <= 1'b1;
      cpu_hold <= 1'b1;
      ld_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (ld_fire) begin
            if (ld_count != CNT_MAX) begin
              ld_count <= ld_count + 1'b1;
            end
            if (ld_last) begin
              state    <= RELEASE;
              ld_ready <= 1'b0;
            end
          end
        end
        RELEASE: begin
          state    <= RUN;
          cpu_hold <= 1'b0;
        end
        RUN: begin
          state    <= RUN;
        end
        default: begin
          state    <= BOOT;
          ld_ready <= 1'b1;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

  cpu_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .rd_en (rd_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (data_out)
  );

endmodule
